// File: rtl/mdu_pkg.sv
// rtl/mdu_pkg.sv - shared op codes, FSM encoding and helpers for the MDU sequencer
package mdu_pkg;

  localparam logic [2:0] MDU_MUL    = 3'b000;
  localparam logic [2:0] MDU_MULH   = 3'b001;
  localparam logic [2:0] MDU_MULHSU = 3'b010;
  localparam logic [2:0] MDU_MULHU  = 3'b011;
  localparam logic [2:0] MDU_DIV    = 3'b100;
  localparam logic [2:0] MDU_DIVU   = 3'b101;
  localparam logic [2:0] MDU_REM    = 3'b110;
  localparam logic [2:0] MDU_REMU   = 3'b111;

  localparam int MDU_ITERS = 32;
  localparam int MDU_CNT_W = $clog2(MDU_ITERS);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } mdu_state_e;

  // Magnitude of a value that is only treated as two's complement when is_signed is set.
  function automatic logic [31:0] abs32(input logic [31:0] v, input logic is_signed);
    return (is_signed && v[31]) ? (~v + 32'd1) : v;
  endfunction

endpackage

// File: rtl/mdu_sequencer_if.sv
// rtl/mdu_sequencer_if.sv - decode-side request and commit-side result bundle of the MDU
interface mdu_sequencer_if;

  logic        mdu_en;
  logic [2:0]  funct3;
  logic [31:0] rs1_data;
  logic [31:0] rs2_data;
  logic        kill;
  logic        stall;
  logic        result_valid;
  logic [31:0] result;

  modport master (
    output mdu_en, funct3, rs1_data, rs2_data, kill,
    input  stall, result_valid, result
  );

  modport slave (
    input  mdu_en, funct3, rs1_data, rs2_data, kill,
    output stall, result_valid, result
  );

endinterface

// File: rtl/mdu_iter_step.sv
// rtl/mdu_iter_step.sv - one radix-2 shift-add or restoring-divide iteration
module mdu_iter_step
  import mdu_pkg::*;
(
  input  logic        is_div,
  input  logic [63:0] acc_i,
  input  logic [31:0] opnd_i,
  output logic [63:0] acc_o
);

  // acc holds {partial product, multiplier} for MUL and {remainder, dividend/quotient} for DIV.
  logic [32:0] add_sum;
  logic [33:0] trial;

  assign add_sum = {1'b0, acc_i[63:32]} + (acc_i[0] ? {1'b0, opnd_i} : 33'd0);
  assign trial   = {1'b0, acc_i[63:31]} - {2'b00, opnd_i};

  always_comb begin
    acc_o = {add_sum, acc_i[31:1]};
    if (is_div) begin
      if (trial[33]) begin
        acc_o = {acc_i[62:0], 1'b0};
      end else begin
        acc_o = {trial[31:0], acc_i[30:0], 1'b1};
      end
    end
  end

endmodule

// File: rtl/mdu_sequencer.sv
// rtl/mdu_sequencer.sv - multi-cycle MUL/DIV/REM controller stalling the single-cycle core
module mdu_sequencer
  import mdu_pkg::*;
#(
  parameter bit ENABLE_MUL = 1'b1,
  parameter bit ENABLE_DIV = 1'b1
) (
  input  logic            clk,
  input  logic            rst,
  mdu_sequencer_if.slave  bus
);

  mdu_state_e           state_q, state_d;
  logic [MDU_CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]           op_q, op_d;
  logic [63:0]          acc_q, acc_d;
  logic [31:0]          opnd_q, opnd_d;
  logic                 neg_q, neg_d;
  logic                 neg_rem_q, neg_rem_d;
  logic                 rv_q, rv_d;
  logic [31:0]          res_q, res_d;

  logic        accept;
  logic        in_div;
  logic        a_signed, b_signed;
  logic        a_neg, b_neg;
  logic [31:0] a_mag, b_mag;
  logic        op_disabled, div_zero, div_ovf, fast;
  logic [31:0] fast_res;
  logic        last_iter;
  logic [63:0] step_acc;
  logic [63:0] prod;
  logic [31:0] quo, rem;
  logic [31:0] final_res;

  assign accept    = (state_q == ST_IDLE) && bus.mdu_en && !bus.kill;
  assign in_div    = bus.funct3[2];
  assign a_signed  = in_div ? !bus.funct3[0]
                            : (bus.funct3 == MDU_MULH) || (bus.funct3 == MDU_MULHSU);
  assign b_signed  = in_div ? !bus.funct3[0] : (bus.funct3 == MDU_MULH);
  assign a_neg     = a_signed && bus.rs1_data[31];
  assign b_neg     = b_signed && bus.rs2_data[31];
  assign a_mag     = abs32(bus.rs1_data, a_signed);
  assign b_mag     = abs32(bus.rs2_data, b_signed);

  assign op_disabled = in_div ? !ENABLE_DIV : !ENABLE_MUL;
  assign div_zero    = in_div && (bus.rs2_data == 32'd0);
  assign div_ovf     = in_div && !bus.funct3[0] &&
                       (bus.rs1_data == 32'h8000_0000) && (bus.rs2_data == 32'hFFFF_FFFF);
  assign fast        = op_disabled || div_zero || div_ovf;

  // Ops that never iterate resolve their result in the accept cycle.
  always_comb begin
    fast_res = 32'd0;
    if (!op_disabled) begin
      if (div_zero) begin
        fast_res = bus.funct3[1] ? bus.rs1_data : 32'hFFFF_FFFF;
      end else if (div_ovf) begin
        fast_res = bus.funct3[1] ? 32'd0 : 32'h8000_0000;
      end
    end
  end

  assign last_iter = (state_q == ST_BUSY) && (cnt_q == MDU_CNT_W'(MDU_ITERS - 1));

  mdu_iter_step u_step (
    .is_div (op_q[2]),
    .acc_i  (acc_q),
    .opnd_i (opnd_q),
    .acc_o  (step_acc)
  );

  // Sign fix-up is applied to the output of the last iteration so DONE follows directly.
  assign prod = neg_q ? (~step_acc + 64'd1) : step_acc;
  assign quo  = neg_q ? (~step_acc[31:0] + 32'd1) : step_acc[31:0];
  assign rem  = neg_rem_q ? (~step_acc[63:32] + 32'd1) : step_acc[63:32];

  always_comb begin
    case (op_q)
      MDU_MUL:                        final_res = prod[31:0];
      MDU_MULH, MDU_MULHSU, MDU_MULHU: final_res = prod[63:32];
      MDU_DIV, MDU_DIVU:              final_res = quo;
      default:                        final_res = rem;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (bus.kill) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: if (bus.mdu_en) state_d = fast ? ST_DONE : ST_BUSY;
        ST_BUSY: if (last_iter) state_d = ST_DONE;
        ST_DONE: state_d = ST_IDLE;
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    bus.stall = 1'b0;
    if (!rst && !bus.kill) begin
      case (state_q)
        ST_IDLE: bus.stall = bus.mdu_en;
        ST_BUSY: bus.stall = 1'b1;
        default: bus.stall = 1'b0;
      endcase
    end
    // A flush in the commit cycle must still suppress the write.
    bus.result_valid = rv_q && !bus.kill;
    bus.result       = res_q;
  end

  always_comb begin
    op_d      = op_q;
    opnd_d    = opnd_q;
    acc_d     = acc_q;
    neg_d     = neg_q;
    neg_rem_d = neg_rem_q;
    cnt_d     = cnt_q;
    rv_d      = 1'b0;
    res_d     = res_q;
    if (accept) begin
      op_d      = bus.funct3;
      opnd_d    = in_div ? b_mag : a_mag;
      acc_d     = {32'd0, (in_div ? a_mag : b_mag)};
      neg_d     = a_neg ^ b_neg;
      neg_rem_d = a_neg;
      cnt_d     = '0;
      if (fast) begin
        rv_d  = 1'b1;
        res_d = fast_res;
      end
    end else if ((state_q == ST_BUSY) && !bus.kill) begin
      acc_d = step_acc;
      cnt_d = cnt_q + MDU_CNT_W'(1);
      if (last_iter) begin
        rv_d  = 1'b1;
        res_d = final_res;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q     <= '0;
      op_q      <= 3'd0;
      acc_q     <= 64'd0;
      opnd_q    <= 32'd0;
      neg_q     <= 1'b0;
      neg_rem_q <= 1'b0;
      rv_q      <= 1'b0;
      res_q     <= 32'd0;
    end else begin
      cnt_q     <= cnt_d;
      op_q      <= op_d;
      acc_q     <= acc_d;
      opnd_q    <= opnd_d;
      neg_q     <= neg_d;
      neg_rem_q <= neg_rem_d;
      rv_q      <= rv_d;
      res_q     <= res_d;
    end
  end

endmodule

// File: tb/tb_mdu_sequencer.sv
// tb/tb_mdu_sequencer.sv - self-checking bench: full, no-divide and no-multiply builds side by side
module tb_mdu_sequencer;
  import mdu_pkg::*;

  localparam bit [2:0] EN_MUL_MASK = 3'b011;
  localparam bit [2:0] EN_DIV_MASK = 3'b101;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        tb_en   [3];
  logic [2:0]  tb_f3   [3];
  logic [31:0] tb_a    [3];
  logic [31:0] tb_b    [3];
  logic        tb_kill [3];
  logic        o_stall [3];
  logic        o_rv    [3];
  logic [31:0] o_res   [3];

  int n_cmp = 0;
  int n_bad = 0;

  mdu_sequencer_if if0 ();
  mdu_sequencer_if if1 ();
  mdu_sequencer_if if2 ();

  mdu_sequencer #(.ENABLE_MUL(1'b1), .ENABLE_DIV(1'b1)) u_dut0 (.clk(clk), .rst(rst), .bus(if0));
  mdu_sequencer #(.ENABLE_MUL(1'b1), .ENABLE_DIV(1'b0)) u_dut1 (.clk(clk), .rst(rst), .bus(if1));
  mdu_sequencer #(.ENABLE_MUL(1'b0), .ENABLE_DIV(1'b1)) u_dut2 (.clk(clk), .rst(rst), .bus(if2));

  assign if0.mdu_en = tb_en[0];  assign if0.funct3 = tb_f3[0];
  assign if0.rs1_data = tb_a[0]; assign if0.rs2_data = tb_b[0]; assign if0.kill = tb_kill[0];
  assign if1.mdu_en = tb_en[1];  assign if1.funct3 = tb_f3[1];
  assign if1.rs1_data = tb_a[1]; assign if1.rs2_data = tb_b[1]; assign if1.kill = tb_kill[1];
  assign if2.mdu_en = tb_en[2];  assign if2.funct3 = tb_f3[2];
  assign if2.rs1_data = tb_a[2]; assign if2.rs2_data = tb_b[2]; assign if2.kill = tb_kill[2];
  assign o_stall[0] = if0.stall; assign o_rv[0] = if0.result_valid; assign o_res[0] = if0.result;
  assign o_stall[1] = if1.stall; assign o_rv[1] = if1.result_valid; assign o_res[1] = if1.result;
  assign o_stall[2] = if2.stall; assign o_rv[2] = if2.result_valid; assign o_res[2] = if2.result;

  task automatic chk(input string tag, input int dut, input int k,
                     input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s dut%0d cycle=%0d observed=%h expected=%h", tag, dut, k, obs, exp);
    end
  endtask

  // Architectural result and commit latency straight from the ISA rules.
  function automatic void model(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                                input bit en_mul, input bit en_div,
                                output logic [31:0] res, output int lat);
    logic [63:0] p;
    int sa, sb;
    sa = a; sb = b; lat = 34; res = 32'd0; p = 64'd0;
    if (!f3[2]) begin
      if (!en_mul) lat = 2;
      else begin
        case (f3[1:0])
          2'b00:   p = {32'd0, a} * {32'd0, b};
          2'b01:   p = {{32{a[31]}}, a} * {{32{b[31]}}, b};
          2'b10:   p = {{32{a[31]}}, a} * {32'd0, b};
          default: p = {32'd0, a} * {32'd0, b};
        endcase
        res = (f3[1:0] == 2'b00) ? p[31:0] : p[63:32];
      end
    end else if (!en_div) begin
      lat = 2;
    end else if (b == 32'd0) begin
      lat = 2; res = f3[1] ? a : 32'hFFFF_FFFF;
    end else if (!f3[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
      lat = 2; res = f3[1] ? 32'd0 : 32'h8000_0000;
    end else begin
      case (f3)
        3'b100:  res = sa / sb;
        3'b101:  res = a / b;
        3'b110:  res = sa % sb;
        default: res = a % b;
      endcase
    end
  endfunction

  // Issue one op to all three builds; each holds mdu_en until it commits, then drops it.
  task automatic run_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                        input bit has_exp, input logic [31:0] exp0);
    logic [31:0] exp [3];
    int lat [3];
    for (int i = 0; i < 3; i++) model(f3, a, b, EN_MUL_MASK[i], EN_DIV_MASK[i], exp[i], lat[i]);
    if (has_exp) exp[0] = exp0;
    @(negedge clk);
    for (int k = 1; k <= 35; k++) begin
      if (k > 1) @(negedge clk);
      for (int i = 0; i < 3; i++) begin
        if (k == 1) begin
          tb_en[i] = 1'b1; tb_f3[i] = f3; tb_a[i] = a; tb_b[i] = b;
        end else if (k == 2) begin
          tb_f3[i] = 3'($urandom); tb_a[i] = $urandom; tb_b[i] = $urandom;
        end
        if (k == lat[i] + 1) tb_en[i] = 1'b0;
      end
      #1;
      for (int i = 0; i < 3; i++) begin
        chk("stall", i, k, 32'(o_stall[i]), 32'(k < lat[i]));
        chk("result_valid", i, k, 32'(o_rv[i]), 32'(k == lat[i]));
        if (k == lat[i]) chk("result", i, k, o_res[i], exp[i]);
      end
    end
  endtask

  // Start an iterating op on the full build and flush it at cycle kk after accept.
  task automatic kill_at(input int kk);
    @(negedge clk);
    for (int k = 1; k <= kk + 36; k++) begin
      if (k > 1) @(negedge clk);
      if (k == 1) begin
        tb_en[0] = 1'b1; tb_f3[0] = MDU_MULHU; tb_a[0] = $urandom; tb_b[0] = $urandom;
      end
      if (k == kk) tb_kill[0] = 1'b1;
      if (k == kk + 1) begin
        tb_kill[0] = 1'b0; tb_en[0] = 1'b0;
      end
      #1;
      chk("kill_stall", 0, k, 32'(o_stall[0]), 32'(k < kk));
      chk("kill_valid", 0, k, 32'(o_rv[0]), 32'd0);
    end
  endtask

  initial begin
    for (int i = 0; i < 3; i++) begin
      tb_en[i] = 1'b0; tb_f3[i] = 3'd0; tb_a[i] = 32'd0; tb_b[i] = 32'd0; tb_kill[i] = 1'b0;
    end
    rst = 1'b1;
    tb_en[0] = 1'b1;
    #2;
    for (int i = 0; i < 3; i++) begin
      chk("reset_stall", i, 0, 32'(o_stall[i]), 32'd0);
      chk("reset_valid", i, 0, 32'(o_rv[i]), 32'd0);
      chk("reset_result", i, 0, o_res[i], 32'd0);
    end
    @(negedge clk);
    tb_en[0] = 1'b0;
    @(negedge clk);
    rst = 1'b0;

    run_op(MDU_MUL,    32'd7,          32'hFFFF_FFFD, 1'b1, 32'hFFFF_FFEB);
    run_op(MDU_MULH,   32'h8000_0000,  32'h8000_0000, 1'b1, 32'h4000_0000);
    run_op(MDU_MULHU,  32'hFFFF_FFFF,  32'hFFFF_FFFF, 1'b1, 32'hFFFF_FFFE);
    run_op(MDU_MULHSU, 32'hFFFF_FFFF,  32'd2,         1'b1, 32'hFFFF_FFFF);
    run_op(MDU_DIVU,   32'd100,        32'd7,         1'b1, 32'd14);
    run_op(MDU_REMU,   32'd100,        32'd7,         1'b1, 32'd2);
    run_op(MDU_DIV,    32'hFFFF_FFF9,  32'd2,         1'b1, 32'hFFFF_FFFD);
    run_op(MDU_REM,    32'hFFFF_FFF9,  32'd2,         1'b1, 32'hFFFF_FFFF);
    run_op(MDU_DIV,    32'd5,          32'd0,         1'b1, 32'hFFFF_FFFF);
    run_op(MDU_REM,    32'd5,          32'd0,         1'b1, 32'd5);
    run_op(MDU_DIV,    32'h8000_0000,  32'hFFFF_FFFF, 1'b1, 32'h8000_0000);
    run_op(MDU_REM,    32'h8000_0000,  32'hFFFF_FFFF, 1'b1, 32'd0);
    run_op(MDU_REMU,   32'h8000_0000,  32'hFFFF_FFFF, 1'b1, 32'h8000_0000);

    kill_at(11);
    run_op(MDU_MUL, 32'd3, 32'd4, 1'b1, 32'd12);
    kill_at(33);
    kill_at(34);
    kill_at(1);
    run_op(MDU_DIVU, 32'd100, 32'd7, 1'b1, 32'd14);

    @(negedge clk);
    tb_en[0] = 1'b1; tb_f3[0] = MDU_DIVU; tb_a[0] = $urandom; tb_b[0] = 32'd3;
    for (int k = 0; k < 15; k++) @(negedge clk);
    rst = 1'b1;
    #1;
    for (int i = 0; i < 3; i++) begin
      chk("midrst_stall", i, 15, 32'(o_stall[i]), 32'd0);
      chk("midrst_valid", i, 15, 32'(o_rv[i]), 32'd0);
      chk("midrst_result", i, 15, o_res[i], 32'd0);
    end
    @(negedge clk);
    tb_en[0] = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      #1;
      chk("post_rst_valid", 0, k, 32'(o_rv[0]), 32'd0);
    end

    for (int n = 0; n < 24; n++) begin
      logic [2:0]  f3;
      logic [31:0] a, b;
      f3 = 3'($urandom_range(0, 7));
      a  = $urandom;
      b  = $urandom;
      case ($urandom_range(0, 5))
        0: b = 32'd0;
        1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
        2: b = $urandom_range(1, 15);
        3: a = $urandom_range(0, 1000);
        default: ;
      endcase
      run_op(f3, a, b, 1'b0, 32'd0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
